// File: rtl/timer_dev_pkg.sv
// Shared definitions for the memory-mapped countdown timer:
// FSM encoding, register offsets, CTRL field positions and modes.
package timer_dev_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_CNT  = 2'd2,
        ST_INT  = 2'd3
    } state_e;

    localparam logic [1:0] ADDR_CTRL   = 2'd0;
    localparam logic [1:0] ADDR_PRESET = 2'd1;
    localparam logic [1:0] ADDR_COUNT  = 2'd2;

    localparam logic [1:0] MODE_ONESHOT = 2'b00;
    localparam logic [1:0] MODE_RELOAD  = 2'b01;

    localparam int CTRL_EN      = 0;
    localparam int CTRL_MODE_LO = 1;
    localparam int CTRL_MODE_HI = 2;
    localparam int CTRL_IM      = 3;
    localparam int CTRL_W       = 4;

endpackage

// File: rtl/timer_dev.sv
// Programmable countdown timer on the system bridge: CTRL/PRESET/COUNT
// registers, a four-state countdown FSM and a combinational read port.
module timer_dev
    import timer_dev_pkg::*;
#(
    parameter logic [31:0] PRESET_RST = 32'd0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  Addr,
    input  logic        WE,
    input  logic [31:0] Din,
    output logic [31:0] Dout,
    output logic        IRQ
);

    logic [CTRL_W-1:0] ctrl_q, ctrl_d;
    logic [31:0]       preset_q, preset_d;
    logic [31:0]       count_q, count_d;
    logic              irq_flag_q, irq_flag_d;
    state_e            state_q, state_d;

    always_comb begin
        ctrl_d     = ctrl_q;
        preset_d   = preset_q;
        count_d    = count_q;
        irq_flag_d = irq_flag_q;
        state_d    = state_q;

        case (state_q)
            ST_IDLE: if (ctrl_q[CTRL_EN]) state_d = ST_LOAD;
            ST_LOAD: begin
                count_d = preset_q;
                state_d = ST_CNT;
            end
            ST_CNT: begin
                if (!ctrl_q[CTRL_EN]) begin
                    state_d = ST_IDLE;
                end else if (count_q > 32'd1) begin
                    count_d = count_q - 32'd1;
                end else begin
                    count_d    = '0;
                    irq_flag_d = 1'b1;
                    state_d    = ST_INT;
                end
            end
            ST_INT: begin
                // Reload mode keeps Enable so IDLE re-arms on its own; any other mode stops.
                if (ctrl_q[CTRL_MODE_HI:CTRL_MODE_LO] == MODE_RELOAD) irq_flag_d = 1'b0;
                else ctrl_d[CTRL_EN] = 1'b0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // CPU writes are applied last so they override the FSM on the same edge.
        if (WE) begin
            case (Addr)
                ADDR_CTRL: begin
                    ctrl_d     = Din[CTRL_W-1:0];
                    irq_flag_d = 1'b0;
                    if (!Din[CTRL_EN]) state_d = ST_IDLE;
                end
                ADDR_PRESET: preset_d = Din;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ctrl_q     <= '0;
            preset_q   <= PRESET_RST;
            count_q    <= '0;
            irq_flag_q <= 1'b0;
            state_q    <= ST_IDLE;
        end else begin
            ctrl_q     <= ctrl_d;
            preset_q   <= preset_d;
            count_q    <= count_d;
            irq_flag_q <= irq_flag_d;
            state_q    <= state_d;
        end
    end

    always_comb begin
        case (Addr)
            ADDR_CTRL:   Dout = {{(32-CTRL_W){1'b0}}, ctrl_q};
            ADDR_PRESET: Dout = preset_q;
            ADDR_COUNT:  Dout = count_q;
            default:     Dout = '0;
        endcase
    end

    assign IRQ = ctrl_q[CTRL_IM] & irq_flag_q;

endmodule

// File: tb/tb_timer_dev.sv
// Randomized and directed bench for timer_dev against a behavioural model.
module tb_timer_dev;

    localparam logic [31:0] PRST = 32'd5;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  Addr;
    logic        WE;
    logic [31:0] Din;
    logic [31:0] Dout;
    logic        IRQ;

    int checks = 0;
    int fails  = 0;

    timer_dev #(.PRESET_RST(PRST)) dut (
        .clk(clk), .reset(rst_n), .Addr(Addr), .WE(WE), .Din(Din),
        .Dout(Dout), .IRQ(IRQ)
    );

    always #5 clk = ~clk;

    // Behavioural model: phase 0 idle, 1 load, 2 counting, 3 expired.
    logic [3:0]  m_ctrl;
    logic [31:0] m_preset, m_cnt;
    logic        m_flag;
    int          m_ph;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s act=%h exp=%h t=%0t", tag, act, exp, $time);
        end
    endtask

    task automatic m_reset();
        m_ctrl = 4'd0; m_preset = PRST; m_cnt = 0; m_flag = 1'b0; m_ph = 0;
    endtask

    function automatic logic [31:0] m_read(input logic [1:0] a);
        if (a == 2'd0) return {28'd0, m_ctrl};
        if (a == 2'd1) return m_preset;
        if (a == 2'd2) return m_cnt;
        return 32'd0;
    endfunction

    function automatic logic m_irq();
        return m_ctrl[3] && m_flag;
    endfunction

    task automatic m_step(input logic we, input logic [1:0] a, input logic [31:0] d);
        logic [3:0]  nc = m_ctrl;
        logic [31:0] np = m_preset, nn = m_cnt;
        logic        nf = m_flag;
        int          nph = m_ph;
        if (m_ph == 0 && m_ctrl[0]) nph = 1;
        else if (m_ph == 1) begin nn = m_preset; nph = 2; end
        else if (m_ph == 2) begin
            if (!m_ctrl[0]) nph = 0;
            else if (m_cnt > 1) nn = m_cnt - 1;
            else begin nn = 0; nf = 1'b1; nph = 3; end
        end else if (m_ph == 3) begin
            if (m_ctrl[2:1] == 2'b01) nf = 1'b0; else nc[0] = 1'b0;
            nph = 0;
        end
        if (we && a == 2'd0) begin
            nc = d[3:0]; nf = 1'b0;
            if (!d[0]) nph = 0;
        end
        if (we && a == 2'd1) np = d;
        m_ctrl = nc; m_preset = np; m_cnt = nn; m_flag = nf; m_ph = nph;
    endtask

    // One clock: drive, check current outputs against the model, then advance both.
    task automatic cyc(input logic we, input logic [1:0] a, input logic [31:0] d);
        WE = we; Addr = a; Din = d;
        #1;
        check("dout", Dout, m_read(a));
        check("irq", {31'd0, IRQ}, {31'd0, m_irq()});
        @(posedge clk);
        m_step(we, a, d);
        @(negedge clk);
    endtask

    task automatic peek(input string tag, input logic [1:0] a, input logic [31:0] exp);
        WE = 1'b0; Addr = a;
        #1;
        check(tag, Dout, exp);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 2'd2, 32'd0);
    endtask

    task automatic quiesce();
        cyc(1'b1, 2'd0, 32'd0);
        idle(2);
    endtask

    initial begin
        int last, nirq, first;
        logic [1:0]  ra;
        logic [31:0] rd;
        logic        rw;

        // Reset held with write traffic present
        rst_n = 1'b0; WE = 1'b1; Addr = 2'd0; Din = $urandom;
        m_reset();
        for (int i = 0; i < 3; i++) begin
            Din = $urandom; Addr = 2'($urandom_range(0, 3));
            @(posedge clk); #1;
        end
        Din = $urandom;
        for (int a = 0; a < 4; a++) begin
            Addr = 2'(a); #1;
            check("rst_read", Dout, (a == 1) ? PRST : 32'd0);
        end
        check("rst_irq", {31'd0, IRQ}, 32'd0);
        @(negedge clk);
        WE = 1'b0; rst_n = 1'b1;
        idle(4);
        peek("idle_count", 2'd2, 32'd0);

        // Countdown from the reset PRESET value
        cyc(1'b1, 2'd0, 32'h9);
        idle(10);
        quiesce();

        // One-shot, PRESET=3
        cyc(1'b1, 2'd1, 32'd3);
        cyc(1'b1, 2'd0, 32'h9);               // e0
        idle(2);                              // e1, e2
        peek("os_c3", 2'd2, 32'd3);
        idle(1); peek("os_c2", 2'd2, 32'd2);
        idle(1); peek("os_c1", 2'd2, 32'd1);
        idle(1); peek("os_c0", 2'd2, 32'd0);
        check("os_irq_on", {31'd0, IRQ}, 32'd1);
        idle(1); peek("os_en_off", 2'd0, 32'h8);
        idle(3);
        check("os_irq_hold", {31'd0, IRQ}, 32'd1);
        cyc(1'b1, 2'd0, 32'h8);
        check("os_irq_clr", {31'd0, IRQ}, 32'd0);
        quiesce();

        // Auto-reload, PRESET=2: period 5
        cyc(1'b1, 2'd1, 32'd2);
        cyc(1'b1, 2'd0, 32'hB);
        last = -1; nirq = 0; first = -1;
        for (int k = 1; k <= 30; k++) begin
            cyc(1'b0, 2'd2, 32'd0);
            if (IRQ) begin
                if (last >= 0) check("ar_period", 32'(k - last), 32'd5);
                else first = k;
                last = k; nirq++;
            end
        end
        check("ar_first", 32'(first), 32'd4);
        check("ar_count", 32'(nirq), 32'd6);
        quiesce();

        // Masked expiry
        cyc(1'b1, 2'd1, 32'd2);
        cyc(1'b1, 2'd0, 32'h1);
        idle(4);
        check("mask_irq", {31'd0, IRQ}, 32'd0);
        idle(1);
        cyc(1'b1, 2'd0, 32'h9);
        check("mask_clr", {31'd0, IRQ}, 32'd0);
        idle(4);
        check("mask_next", {31'd0, IRQ}, 32'd1);
        quiesce();

        // Disable mid-count at COUNT=6
        cyc(1'b1, 2'd1, 32'd10);
        cyc(1'b1, 2'd0, 32'h1);               // e0
        idle(5);
        cyc(1'b1, 2'd0, 32'h0);               // e6
        peek("dis_cnt", 2'd2, 32'd6);
        idle(3);
        peek("dis_hold", 2'd2, 32'd6);
        cyc(1'b1, 2'd2, 32'h55);
        peek("cnt_ro", 2'd2, 32'd6);
        cyc(1'b1, 2'd3, 32'hFFFF_FFFF);
        peek("rsvd", 2'd3, 32'd0);
        check("dis_irq", {31'd0, IRQ}, 32'd0);
        quiesce();

        // CTRL write colliding with expiry
        cyc(1'b1, 2'd1, 32'd2);
        cyc(1'b1, 2'd0, 32'h9);               // e0
        idle(3);
        cyc(1'b1, 2'd0, 32'h9);               // e4, same edge as expiry
        peek("col_ctrl", 2'd0, 32'h9);
        peek("col_cnt", 2'd2, 32'd0);
        for (int k = 0; k < 8; k++) begin
            cyc(1'b0, 2'd2, 32'd0);
            check("col_irq", {31'd0, IRQ}, 32'd0);
        end
        peek("col_noreload", 2'd2, 32'd0);
        quiesce();

        // Asynchronous reset mid-count
        cyc(1'b1, 2'd1, 32'd20);
        cyc(1'b1, 2'd0, 32'h9);
        idle(6);
        #2 rst_n = 1'b0;
        m_reset();
        peek("arst_cnt", 2'd2, 32'd0);
        peek("arst_pre", 2'd1, PRST);
        peek("arst_ctrl", 2'd0, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            rw = ($urandom_range(0, 5) == 0);
            ra = 2'($urandom_range(0, 3));
            if (ra == 2'd1) rd = $urandom_range(0, 6);
            else if (ra == 2'd0) rd = ($urandom & 32'hFFFF_FFF0) | 32'($urandom_range(0, 15));
            else rd = $urandom;
            cyc(rw, ra, rd);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
